// File: rtl/instr_sequencer_pkg.sv
`default_nettype none
// instr_sequencer_pkg: opcodes, FSM states, LU op codes and instruction field positions.
// Revision 1.0 - initial release.
package instr_sequencer_pkg;

    localparam logic [3:0] OP_NOOP    = 4'h0;
    localparam logic [3:0] OP_LU_LAST = 4'h7;
    localparam logic [3:0] OP_ARITH_A = 4'h8;
    localparam logic [3:0] OP_ARITH_B = 4'h9;
    localparam logic [3:0] OP_LDI     = 4'hA;
    localparam logic [3:0] OP_JMP     = 4'hB;
    localparam logic [3:0] OP_JZ      = 4'hC;
    localparam logic [3:0] OP_ST      = 4'hD;
    localparam logic [3:0] OP_RSVD    = 4'hE;
    localparam logic [3:0] OP_HALT    = 4'hF;

    localparam logic [2:0] LUOP_NONE    = 3'b000;
    localparam logic [2:0] LUOP_ARITH_A = 3'b001;
    localparam logic [2:0] LUOP_ARITH_B = 3'b010;

    localparam int OPC_MSB  = 7;
    localparam int OPC_LSB  = 4;
    localparam int OPND_MSB = 3;
    localparam int OPND_LSB = 0;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_HALT   = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/instr_sequencer_decode.sv
`default_nettype none
// instr_decode: combinational opcode classification for the sequencer.
// Revision 1.0 - initial release.
module instr_decode
    import instr_sequencer_pkg::*;
(
    input  logic [3:0] opcode,
    output logic [2:0] luop,
    output logic       arith,
    output logic       lu_en,
    output logic       acc_we_en,
    output logic       acc_src,
    output logic       st_en,
    output logic       jmp,
    output logic       jz,
    output logic       halt
);

    always_comb begin
        luop      = LUOP_NONE;
        arith     = 1'b0;
        lu_en     = 1'b0;
        acc_we_en = 1'b0;
        acc_src   = 1'b0;
        st_en     = 1'b0;
        jmp       = 1'b0;
        jz        = 1'b0;
        halt      = 1'b0;
        case (opcode)
            OP_ARITH_A: begin
                luop      = LUOP_ARITH_A;
                arith     = 1'b1;
                lu_en     = 1'b1;
                acc_we_en = 1'b1;
            end
            OP_ARITH_B: begin
                luop      = LUOP_ARITH_B;
                arith     = 1'b1;
                lu_en     = 1'b1;
                acc_we_en = 1'b1;
            end
            OP_LDI: begin
                acc_we_en = 1'b1;
                acc_src   = 1'b1;
            end
            OP_JMP:  jmp   = 1'b1;
            OP_JZ:   jz    = 1'b1;
            OP_ST:   st_en = 1'b1;
            OP_HALT: halt  = 1'b1;
            default: begin
                // Remaining codes are NOOP, reserved, or the plain LU range 1..7
                if (opcode != OP_NOOP && opcode <= OP_LU_LAST) begin
                    luop      = opcode[2:0];
                    lu_en     = 1'b1;
                    acc_we_en = 1'b1;
                end
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/instr_sequencer.sv
`default_nettype none
// instr_sequencer: fetch/decode/execute controller driving the LU and accumulator strobes.
// Revision 1.0 - initial release.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int          PC_W     = 8,
    parameter int unsigned RESET_PC = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    output logic            mem_req,
    output logic [PC_W-1:0] mem_addr,
    input  logic            mem_ack,
    input  logic [7:0]      mem_rdata,
    input  logic            zero_flag,
    output logic [2:0]      LUOP,
    output logic            arith,
    output logic            lu_go,
    output logic            acc_we,
    output logic            acc_src,
    output logic [3:0]      imm,
    output logic            st_we,
    output logic [PC_W-1:0] pc,
    output logic            halted
);

    state_t     state;
    state_t     state_next;
    logic [7:0] ir;

    logic [2:0] dec_luop;
    logic       dec_arith;
    logic       dec_lu_en;
    logic       dec_acc_we;
    logic       dec_acc_src;
    logic       dec_st_en;
    logic       dec_jmp;
    logic       dec_jz;
    logic       dec_halt;

    instr_decode u_decode (
        .opcode    (ir[OPC_MSB:OPC_LSB]),
        .luop      (dec_luop),
        .arith     (dec_arith),
        .lu_en     (dec_lu_en),
        .acc_we_en (dec_acc_we),
        .acc_src   (dec_acc_src),
        .st_en     (dec_st_en),
        .jmp       (dec_jmp),
        .jz        (dec_jz),
        .halt      (dec_halt)
    );

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (run) state_next = S_FETCH;
            S_FETCH:  if (mem_ack) state_next = S_DECODE;
            S_DECODE: state_next = S_EXEC;
            S_EXEC: begin
                if (dec_halt)  state_next = S_HALT;
                else if (run)  state_next = S_FETCH;
                else           state_next = S_IDLE;
            end
            S_HALT:   state_next = S_HALT;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            pc      <= PC_W'(RESET_PC);
            ir      <= 8'h00;
            LUOP    <= LUOP_NONE;
            arith   <= 1'b0;
            imm     <= 4'h0;
            acc_src <= 1'b0;
            lu_go   <= 1'b0;
            acc_we  <= 1'b0;
            st_we   <= 1'b0;
        end else begin
            state  <= state_next;
            lu_go  <= 1'b0;
            acc_we <= 1'b0;
            st_we  <= 1'b0;
            case (state)
                S_FETCH: begin
                    if (mem_ack) begin
                        ir <= mem_rdata;
                        pc <= pc + PC_W'(1);
                    end
                end
                S_DECODE: begin
                    // Strobes are registered here so they are high for exactly the EXEC cycle
                    imm     <= ir[OPND_MSB:OPND_LSB];
                    acc_src <= dec_acc_src;
                    lu_go   <= dec_lu_en;
                    acc_we  <= dec_acc_we;
                    st_we   <= dec_st_en;
                    if (dec_lu_en) begin
                        LUOP  <= dec_luop;
                        arith <= dec_arith;
                    end
                end
                S_EXEC: begin
                    if (dec_jmp || (dec_jz && zero_flag))
                        pc <= PC_W'(imm);
                end
                default: ;
            endcase
        end
    end

    assign mem_req  = (state == S_FETCH);
    assign mem_addr = pc;
    assign halted   = (state == S_HALT);

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// tb_instr_sequencer: randomized and directed checks against an instruction-level reference model.
// Revision 1.0 - initial release.
module tb_instr_sequencer;

    localparam int          PC_W     = 8;
    localparam int unsigned RESET_PC = 250;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            run;
    logic            mem_req;
    logic [PC_W-1:0] mem_addr;
    logic            mem_ack;
    logic [7:0]      mem_rdata;
    logic            zero_flag;
    logic [2:0]      LUOP;
    logic            arith;
    logic            lu_go;
    logic            acc_we;
    logic            acc_src;
    logic [3:0]      imm;
    logic            st_we;
    logic [PC_W-1:0] pc;
    logic            halted;

    int checks   = 0;
    int failures = 0;

    // Architectural reference state
    logic [PC_W-1:0] m_pc;
    logic [2:0]      m_luop;
    logic            m_arith;
    logic [3:0]      m_imm;
    logic            m_halt;

    instr_sequencer #(.PC_W(PC_W), .RESET_PC(RESET_PC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .zero_flag (zero_flag),
        .LUOP      (LUOP),
        .arith     (arith),
        .lu_go     (lu_go),
        .acc_we    (acc_we),
        .acc_src   (acc_src),
        .imm       (imm),
        .st_we     (st_we),
        .pc        (pc),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc    = PC_W'(RESET_PC);
        m_luop  = 3'd0;
        m_arith = 1'b0;
        m_imm   = 4'd0;
        m_halt  = 1'b0;
    endtask

    // One full instruction: optional idle gap, fetch with ack delay, decode, execute, post-check.
    task automatic do_instr(input logic [7:0] ins, input int dly, input bit zf,
                            input bit drop_run, input bit run_after);
        int         n;
        logic [3:0] op;
        logic [3:0] opnd;
        bit         is_lu;
        if (!run) begin
            for (int i = 0; i < 2; i++) begin
                @(negedge clk);
                check_eq("idle_req", 32'(mem_req), 32'd0);
            end
            run = 1'b1;
        end
        n = 0;
        while (!mem_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("req_seen", 32'(mem_req), 32'd1);
        check_eq("fetch_addr", 32'(mem_addr), 32'(m_pc));
        if (drop_run) run = 1'b0;
        for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            check_eq("req_hold", 32'(mem_req), 32'd1);
            check_eq("addr_hold", 32'(mem_addr), 32'(m_pc));
        end
        mem_ack   = 1'b1;
        mem_rdata = ins;
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = 8'($urandom);
        m_pc      = m_pc + 1'b1;
        check_eq("dec_strobes", 32'({lu_go, acc_we, st_we}), 32'd0);
        check_eq("dec_pc", 32'(pc), 32'(m_pc));
        check_eq("dec_req", 32'(mem_req), 32'd0);
        zero_flag = zf;
        @(negedge clk);
        op    = ins[7:4];
        opnd  = ins[3:0];
        is_lu = (op >= 4'd1) && (op <= 4'd9);
        if (is_lu) begin
            m_luop  = (op <= 4'd7) ? op[2:0] : ((op == 4'd8) ? 3'd1 : 3'd2);
            m_arith = (op >= 4'd8);
        end
        m_imm = opnd;
        check_eq("exec_strobes", 32'({lu_go, acc_we, st_we}),
                 32'({is_lu, is_lu || (op == 4'hA), op == 4'hD}));
        check_eq("exec_luop", 32'(LUOP), 32'(m_luop));
        check_eq("exec_arith", 32'(arith), 32'(m_arith));
        check_eq("exec_imm", 32'(imm), 32'(m_imm));
        check_eq("exec_acc_src", 32'(acc_src), 32'(op == 4'hA));
        run = run_after;
        if (op == 4'hB || (op == 4'hC && zf)) m_pc = PC_W'(opnd);
        if (op == 4'hF) m_halt = 1'b1;
        @(negedge clk);
        check_eq("post_pc", 32'(pc), 32'(m_pc));
        check_eq("post_strobes", 32'({lu_go, acc_we, st_we}), 32'd0);
        check_eq("post_halted", 32'(halted), 32'(m_halt));
        check_eq("post_req", 32'(mem_req), 32'(run_after && !m_halt));
        zero_flag = 1'($urandom);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] ins;
        rst_n     = 1'b0;
        run       = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
        zero_flag = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_eq("rst_req", 32'(mem_req), 32'd0);
        check_eq("rst_pc", 32'(pc), 32'(m_pc));
        check_eq("rst_halted", 32'(halted), 32'd0);
        check_eq("rst_luop", 32'({LUOP, arith, acc_src}), 32'd0);
        check_eq("rst_imm", 32'(imm), 32'd0);
        check_eq("rst_strobes", 32'({lu_go, acc_we, st_we}), 32'd0);

        // Directed program starting at RESET_PC, walking through the pc wrap
        do_instr(8'h13, 0, 1'b0, 1'b0, 1'b1);
        do_instr(8'h85, 0, 1'b0, 1'b0, 1'b1);
        do_instr(8'h9F, 1, 1'b0, 1'b0, 1'b1);
        do_instr(8'hA9, 4, 1'b0, 1'b0, 1'b1);
        do_instr(8'hD4, 0, 1'b0, 1'b0, 1'b1);
        do_instr(8'h00, 0, 1'b0, 1'b0, 1'b1);
        check_eq("pc_wrap", 32'(pc), 32'd0);
        do_instr(8'hC3, 0, 1'b0, 1'b0, 1'b1);
        do_instr(8'hC3, 0, 1'b1, 1'b0, 1'b1);
        do_instr(8'hB7, 2, 1'b0, 1'b0, 1'b1);
        do_instr(8'hE5, 0, 1'b0, 1'b1, 1'b0);

        // Randomized instruction stream (HALT excluded until the end)
        for (int k = 0; k < 200; k++) begin
            ins = 8'($urandom);
            if (ins[7:4] == 4'hF) ins[7:4] = 4'hE;
            do_instr(ins, int'($urandom_range(0, 3)), 1'($urandom),
                     ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0));
        end

        // HALT: no requests regardless of run, then a single reset edge
        do_instr(8'hF0, 0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            run = 1'($urandom);
            @(negedge clk);
            check_eq("halt_req", 32'(mem_req), 32'd0);
            check_eq("halt_flag", 32'(halted), 32'd1);
            check_eq("halt_pc", 32'(pc), 32'(m_pc));
        end
        run   = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        check_eq("unhalt_flag", 32'(halted), 32'd0);
        check_eq("unhalt_pc", 32'(pc), 32'(m_pc));
        check_eq("unhalt_req", 32'(mem_req), 32'd0);
        check_eq("unhalt_luop", 32'({LUOP, arith}), 32'd0);

        // Reset in the middle of a fetch, with a late ack afterwards
        run = 1'b1;
        @(negedge clk);
        check_eq("midrst_req", 32'(mem_req), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
        run       = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 8'h13;
        @(negedge clk);
        mem_ack   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_eq("late_ack_strobes", 32'({lu_go, acc_we, st_we}), 32'd0);
            check_eq("late_ack_req", 32'(mem_req), 32'd0);
            check_eq("late_ack_pc", 32'(pc), 32'(m_pc));
            check_eq("late_ack_luop", 32'(LUOP), 32'd0);
            @(negedge clk);
        end
        do_instr(8'hA9, 0, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
